// File: rtl/cr_prefix_attach_pmw_pkg.sv
// Shared types and constants for the prefix memory writer: FSM states,
// per-prefix word counts, PHD stride and the XP10 CRC32 step over one 64-bit word.
package cr_prefix_attach_pmw_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        WCRC,
        DONE
    } pmw_state_e;

    localparam int N_PFD_WORDS = 128;
    localparam int N_PHD_WORDS = 64;
    localparam int PHD_STRIDE  = 65;

    localparam logic [31:0] XP10_POLY = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_INIT  = 32'hFFFF_FFFF;

    // Data bits enter MSB first, matching the order the prefix reader checks them.
    function automatic logic [31:0] crc32_xp(input logic [63:0] data, input logic [31:0] crc);
        logic [31:0] c;
        c = crc;
        for (int i = 63; i >= 0; i--) begin
            if (c[31] ^ data[i]) begin
                c = {c[30:0], 1'b0} ^ XP10_POLY;
            end else begin
                c = {c[30:0], 1'b0};
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/cr_prefix_attach_pmw.sv
// Prefix memory writer: streams one PFD or PHD prefix into its RAM, accumulates
// the XP10 CRC32 over the beats and stores the inverted CRC in the PFD CRC slot.
module cr_prefix_attach_pmw
    import cr_prefix_attach_pmw_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic        i_cmd_sel,
    input  logic [5:0]  i_cmd_prefix,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic [63:0] i_in_data,
    input  logic        i_in_last,
    input  logic        i_abort,
    output logic        o_mem_req,
    input  logic        i_mem_gnt,
    output logic        o_pfd_mem_we,
    output logic [12:0] o_pfd_mem_addr,
    output logic [63:0] o_pfd_mem_din,
    output logic        o_phd_mem_we,
    output logic [11:0] o_phd_mem_addr,
    output logic [63:0] o_phd_mem_din,
    output logic        o_done,
    output logic        o_done_err,
    output logic [31:0] o_crc_out
);

    pmw_state_e  r_state;
    pmw_state_e  w_nextState;

    logic        r_sel;
    logic [5:0]  r_prefix;
    logic [6:0]  r_cnt;
    logic [31:0] r_crc;
    logic        r_err;
    logic        r_crcIssued;

    logic        r_pfdWe;
    logic [12:0] r_pfdAddr;
    logic [63:0] r_pfdDin;
    logic        r_phdWe;
    logic [11:0] r_phdAddr;
    logic [63:0] r_phdDin;

    logic        w_cmdAccept;
    logic        w_nullPhd;
    logic        w_beat;
    logic [6:0]  w_lastIdx;
    logic        w_atLast;
    logic        w_lenOk;
    logic        w_lenErr;
    logic        w_crcIssue;
    logic [11:0] w_prefixExt;
    logic [11:0] w_phdBase;
    logic [11:0] w_phdAddr;

    assign w_cmdAccept = (r_state == IDLE) && i_cmd_valid && !i_abort;
    assign w_nullPhd   = i_cmd_sel && (i_cmd_prefix == 6'd0);
    assign w_beat      = (r_state == DATA) && i_in_valid && i_mem_gnt && !i_abort;
    assign w_lastIdx   = r_sel ? 7'(N_PHD_WORDS - 1) : 7'(N_PFD_WORDS - 1);
    assign w_atLast    = (r_cnt == w_lastIdx);
    assign w_lenOk     = w_beat && i_in_last && w_atLast;
    assign w_lenErr    = w_beat && (i_in_last ^ w_atLast);
    // The CRC write is issued once; the extra WCRC cycle keeps ownership while it lands.
    assign w_crcIssue  = (r_state == WCRC) && i_mem_gnt && !r_crcIssued && !i_abort;

    // PHD region base wraps modulo the 4096-entry RAM.
    assign w_prefixExt = {6'd0, r_prefix};
    assign w_phdBase   = (w_prefixExt - 12'd1) * 12'(PHD_STRIDE);
    assign w_phdAddr   = w_phdBase + {5'd0, r_cnt};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        if (i_abort) begin
            w_nextState = IDLE;
        end else begin
            unique case (r_state)
                IDLE: if (w_cmdAccept) w_nextState = w_nullPhd ? DONE : DATA;
                DATA: begin
                    if (w_lenOk) begin
                        w_nextState = WCRC;
                    end else if (w_lenErr) begin
                        w_nextState = DONE;
                    end
                end
                WCRC: if (r_crcIssued) w_nextState = DONE;
                DONE: w_nextState = IDLE;
                default: w_nextState = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel       <= 1'b0;
            r_prefix    <= 6'd0;
            r_cnt       <= 7'd0;
            r_crc       <= CRC_INIT;
            r_err       <= 1'b0;
            r_crcIssued <= 1'b0;
        end else if (w_cmdAccept) begin
            r_sel       <= i_cmd_sel;
            r_prefix    <= i_cmd_prefix;
            r_cnt       <= 7'd0;
            r_crc       <= CRC_INIT;
            r_err       <= w_nullPhd;
            r_crcIssued <= 1'b0;
        end else if (w_beat) begin
            r_crc <= crc32_xp(i_in_data, r_crc);
            r_cnt <= r_cnt + 7'd1;
            if (w_lenErr) begin
                r_err <= 1'b1;
            end
        end else if (w_crcIssue) begin
            r_crcIssued <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pfdWe   <= 1'b0;
            r_pfdAddr <= 13'd0;
            r_pfdDin  <= 64'd0;
            r_phdWe   <= 1'b0;
            r_phdAddr <= 12'd0;
            r_phdDin  <= 64'd0;
        end else begin
            r_pfdWe <= 1'b0;
            r_phdWe <= 1'b0;
            if (w_beat && !r_sel) begin
                r_pfdWe   <= 1'b1;
                r_pfdAddr <= {r_prefix, r_cnt};
                r_pfdDin  <= i_in_data;
            end else if (w_beat && r_sel) begin
                r_phdWe   <= 1'b1;
                r_phdAddr <= w_phdAddr;
                r_phdDin  <= i_in_data;
            end else if (w_crcIssue) begin
                r_pfdWe   <= 1'b1;
                r_pfdAddr <= {6'd0, r_sel, r_prefix};
                r_pfdDin  <= {32'd0, ~r_crc};
            end
        end
    end

    // cmd_ready is gated by reset so every output reads 0 while reset is held.
    assign o_cmd_ready    = (r_state == IDLE) && rst_n;
    assign o_in_ready     = (r_state == DATA) && i_mem_gnt;
    assign o_mem_req      = (r_state == DATA) || (r_state == WCRC);
    assign o_pfd_mem_we   = r_pfdWe;
    assign o_pfd_mem_addr = r_pfdAddr;
    assign o_pfd_mem_din  = r_pfdDin;
    assign o_phd_mem_we   = r_phdWe;
    assign o_phd_mem_addr = r_phdAddr;
    assign o_phd_mem_din  = r_phdDin;
    assign o_done         = (r_state == DONE);
    assign o_done_err     = (r_state == DONE) && r_err;
    assign o_crc_out      = (r_state == DONE) ? ~r_crc : 32'd0;

endmodule
